jiajian_disp: RTL

JIAJIAN_DISP -- requirements
Module: jiajian_disp

---
 rtl/jiajian_disp.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jiajian_disp.sv
// Add/sub result display: converts a 7-bit result to sign + 3 BCD digits by
// double-dabble and scans them on a 4-digit active-low 7-segment display.
// Optional macro JIAJIAN_DISP_ZERO_BLANK_EN blanks leading zero digits.
module jiajian_disp #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       sub,
  input  logic [6:0] res,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  state_t      state;
  logic [2:0]  iter;
  logic [18:0] dd;       // {hundreds, tens, ones, binary}
  logic [18:0] dd_adj;
  logic        neg_cap;
  logic [6:0]  mag;

  logic [3:0]  hun, ten, one;
  logic        neg, valid;
  logic [15:0] scan_cnt;
  logic [1:0]  dig_idx;
  logic        blank_h, blank_t;

  assign mag = (sub && res[6]) ? (~res + 7'd1) : res;

  always_comb begin
    dd_adj = dd;
    if (dd[18:15] > 4'd4) dd_adj[18:15] = dd[18:15] + 4'd3;
    if (dd[14:11] > 4'd4) dd_adj[14:11] = dd[14:11] + 4'd3;
    if (dd[10:7]  > 4'd4) dd_adj[10:7]  = dd[10:7]  + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      iter    <= '0;
      dd      <= '0;
      neg_cap <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hun     <= '0;
      ten     <= '0;
      one     <= '0;
      neg     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          dd      <= {12'd0, mag};
          neg_cap <= sub && res[6];
          iter    <= '0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          dd   <= dd_adj << 1;
          iter <= iter + 3'd1;
          if (iter == 3'd6) state <= FIN;
        end
        FIN: begin
          hun   <= dd[18:15];
          ten   <= dd[14:11];
          one   <= dd[10:7];
          neg   <= neg_cap;
          valid <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan keeps free-running across new results; only reset stops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (valid) begin
      if (scan_cnt == SCAN_DIV - 16'd1) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

`ifdef JIAJIAN_DISP_ZERO_BLANK_EN
  assign blank_h = (hun == 4'd0);
  assign blank_t = (hun == 4'd0) && (ten == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    an  = 4'hF;
    seg = SEG_BLANK;
    if (valid) begin
      an = ~(4'b0001 << dig_idx);
      case (dig_idx)
        2'd0:    seg = enc(one);
        2'd1:    seg = blank_t ? SEG_BLANK : enc(ten);
        2'd2:    seg = blank_h ? SEG_BLANK : enc(hun);
        default: seg = neg ? SEG_MINUS : SEG_BLANK;
      endcase
    end
  end

endmodule
